// File: rtl/rob_commit_queue_pkg.sv
// rob_commit_queue_pkg: shared widths and the retire entry type for the commit queue
package rob_commit_queue_pkg;
  localparam int DISPATCH_WIDTH = 2;
  localparam int COMMIT_WIDTH = DISPATCH_WIDTH;
  localparam int PHYS_REGS_ADDR_WIDTH = 6;
  typedef struct packed {
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    logic [4:0]                      arch_rd;
    logic [31:0]                     pc;
    logic [31:0]                     instr;
  } commit_entry_t;
endpackage

// File: rtl/rob_commit_queue_compactor.sv
// commit_lane_compactor: per-lane slot offsets (exclusive prefix popcount) and total enabled lanes
module commit_lane_compactor #(
  parameter int W = 2,
  localparam int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]         en,
  output logic [W-1:0][OW-1:0] off,
  output logic [OW-1:0]        k
);
  always_comb begin
    k = '0;
    for (int i = 0; i < W; i++) begin
      off[i] = k;
      k = k + OW'(en[i]);
    end
  end
endmodule

// File: rtl/rob_commit_queue.sv
// rob_commit_queue: in-order retire buffer, compacts sparse commit lanes, drains oldest-first, counts instret
module rob_commit_queue #(
  parameter int COMMIT_WIDTH = rob_commit_queue_pkg::COMMIT_WIDTH,
  parameter int OUT_WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int PHYS_REGS_ADDR_WIDTH = rob_commit_queue_pkg::PHYS_REGS_ADDR_WIDTH
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [COMMIT_WIDTH-1:0]                          in_en,
  input  logic [COMMIT_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] in_phys_rd,
  input  logic [COMMIT_WIDTH-1:0][4:0]                     in_arch_rd,
  input  logic [COMMIT_WIDTH-1:0][31:0]                    in_pc,
  input  logic [COMMIT_WIDTH-1:0][31:0]                    in_instr,
  output logic                                             in_ready,
  output logic [OUT_WIDTH-1:0]                             out_en,
  output logic [OUT_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]   out_phys_rd,
  output logic [OUT_WIDTH-1:0][4:0]                        out_arch_rd,
  output logic [OUT_WIDTH-1:0][31:0]                       out_pc,
  output logic [OUT_WIDTH-1:0][31:0]                       out_instr,
  input  logic                                             out_ready,
  output logic [$clog2(DEPTH+1)-1:0]                       count,
  output logic [63:0]                                      instret
);
  import rob_commit_queue_pkg::*;
  localparam int PW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int KW = $clog2(COMMIT_WIDTH + 1);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] CW_C = CNTW'(COMMIT_WIDTH);
  commit_entry_t mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [COMMIT_WIDTH-1:0][KW-1:0] off;
  logic [KW-1:0] k;
  logic [CNTW-1:0] k_eff, d;
  commit_lane_compactor #(.W(COMMIT_WIDTH)) u_compactor (.en(in_en), .off(off), .k(k));
  assign in_ready = (DEPTH_C - count) >= CW_C;
  always_comb begin
    k_eff = in_ready ? CNTW'(k) : '0;
    d = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      out_en[i] = count > CNTW'(i);
      out_phys_rd[i] = mem[head + PW'(i)].phys_rd;
      out_arch_rd[i] = mem[head + PW'(i)].arch_rd;
      out_pc[i] = mem[head + PW'(i)].pc;
      out_instr[i] = mem[head + PW'(i)].instr;
      d = d + ((out_ready && out_en[i]) ? CNTW'(1) : '0);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      instret <= '0;
    end else begin
      head <= head + PW'(d);
      tail <= tail + PW'(k_eff);
      count <= count + k_eff - d;
      instret <= instret + 64'(d);
    end
  end
  // storage is intentionally left unreset; only pointers define validity
  always_ff @(posedge clk) begin
    for (int i = 0; i < COMMIT_WIDTH; i++)
      if (in_ready && in_en[i])
        mem[tail + PW'(off[i])] <= '{phys_rd: in_phys_rd[i], arch_rd: in_arch_rd[i], pc: in_pc[i], instr: in_instr[i]};
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count <= DEPTH_C) else $error("count exceeds DEPTH");
      assert (((out_en + OUT_WIDTH'(1)) & out_en) == '0) else $error("out_en not contiguous");
      assert (in_ready || k_eff == '0) else $error("enqueue while not ready");
    end
  end
`endif
endmodule

// File: tb/tb_rob_commit_queue.sv
// tb_rob_commit_queue: directed stimulus with a pc scoreboard checked by an independent output monitor
module tb_rob_commit_queue;
  logic clk = 0, rst_n = 0, in_ready, out_ready = 0;
  logic [1:0] in_en = '0;
  logic [1:0][5:0] in_phys_rd;
  logic [1:0][4:0] in_arch_rd;
  logic [1:0][31:0] in_pc, in_instr;
  logic [0:0] out_en;
  logic [0:0][5:0] out_phys_rd;
  logic [0:0][4:0] out_arch_rd;
  logic [0:0][31:0] out_pc, out_instr;
  logic [3:0] count;
  logic [63:0] instret;
  logic [31:0] exp_q [$];
  logic [31:0] e;
  int checks = 0, failures = 0;

  rob_commit_queue dut (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .in_phys_rd(in_phys_rd), .in_arch_rd(in_arch_rd),
    .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready), .out_en(out_en), .out_phys_rd(out_phys_rd),
    .out_arch_rd(out_arch_rd), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .count(count), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] f_phys(logic [31:0] p); return p[7:2]; endfunction
  function automatic logic [4:0] f_arch(logic [31:0] p); return p[11:7]; endfunction
  function automatic logic [31:0] f_instr(logic [31:0] p); return p ^ 32'hA5A5_0000; endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] en, input logic [31:0] p0, input logic [31:0] p1);
    in_en = en;
    in_pc[0] = p0;
    in_pc[1] = p1;
    for (int j = 0; j < 2; j++) begin
      in_phys_rd[j] = f_phys(in_pc[j]);
      in_arch_rd[j] = f_arch(in_pc[j]);
      in_instr[j] = f_instr(in_pc[j]);
    end
  endtask

  task automatic push(input logic [1:0] en, input logic [31:0] p0, input logic [31:0] p1);
    if (en[0]) exp_q.push_back(p0);
    if (en[1]) exp_q.push_back(p1);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_ready && out_en[0]) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: got pc %0h expected no output", out_pc[0]);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", out_pc[0], e);
        chk("out_phys_rd", out_phys_rd[0], f_phys(e));
        chk("out_arch_rd", out_arch_rd[0], f_arch(e));
        chk("out_instr", out_instr[0], f_instr(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int sent, mcount, idx, k;
    logic [1:0] pat;
    logic [1:0] pats [4] = '{2'b11, 2'b10, 2'b01, 2'b11};
    logic [31:0] p, p0, p1;
    logic orr, rdy, dq;
    drive(2'b00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", count, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_en", out_en, 0);
    chk("reset_instret", instret, 0);
    @(negedge clk) rst_n = 1;
    step();
    // 1: full bundle, visible next cycle
    drive(2'b11, 32'h100, 32'h104);
    push(2'b11, 32'h100, 32'h104);
    step();
    drive(2'b00, 0, 0);
    chk("t1_count", count, 2);
    chk("t1_out_en", out_en, 1);
    chk("t1_out_pc", out_pc[0], 32'h100);
    out_ready = 1;
    step();
    step();
    out_ready = 0;
    chk("t1_drained", count, 0);
    chk("t1_instret", instret, 2);
    // 2: sparse lane 1 compacted to slot 0
    drive(2'b10, 32'h1F0, 32'h200);
    push(2'b10, 32'h1F0, 32'h200);
    step();
    drive(2'b00, 0, 0);
    chk("t2_count", count, 1);
    chk("t2_out_pc", out_pc[0], 32'h200);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("t2_instret", instret, 3);
    // 3: fill to full, fifth bundle held
    for (int b = 0; b < 4; b++) begin
      drive(2'b11, 32'h300 + 8 * b, 32'h304 + 8 * b);
      push(2'b11, 32'h300 + 8 * b, 32'h304 + 8 * b);
      step();
      chk("t3_count", count, 2 * (b + 1));
      chk("t3_in_ready", in_ready, b < 3);
    end
    drive(2'b11, 32'h320, 32'h324);
    step();
    chk("t3_held_count", count, 8);
    chk("t3_held_ready", in_ready, 0);
    // 4: full with drain; bundle accepted once two slots free
    out_ready = 1;
    step();
    chk("t4_count_7", count, 7);
    chk("t4_in_ready_7", in_ready, 0);
    push(2'b11, 32'h320, 32'h324);
    step();
    chk("t4_count_6", count, 6);
    chk("t4_in_ready_6", in_ready, 1);
    step();
    drive(2'b00, 0, 0);
    chk("t4_count_enq", count, 7);
    repeat (7) step();
    out_ready = 0;
    chk("t4_drained", count, 0);
    chk("t4_instret", instret, 13);
    // 5: 20-entry stream with random drain across pointer wrap
    sent = 0;
    mcount = 0;
    idx = 0;
    for (int g = 0; g < 300 && sent < 20; g++) begin
      pat = pats[idx % 4];
      if (20 - sent == 1) pat = 2'b01;
      p = 32'h1000 + 4 * sent;
      p0 = pat == 2'b10 ? 32'hBAD0 : p;
      p1 = pat == 2'b11 ? p + 4 : (pat == 2'b10 ? p : 32'hBAD4);
      orr = 1'($urandom % 2);
      drive(pat, p0, p1);
      out_ready = orr;
      rdy = (8 - mcount) >= 2;
      k = $countones(pat);
      dq = orr && mcount > 0;
      if (rdy) begin
        push(pat, p0, p1);
        sent += k;
        mcount += k;
        idx++;
      end
      if (dq) mcount--;
      step();
      chk("t5_count", count, 64'(mcount));
    end
    drive(2'b00, 0, 0);
    out_ready = 1;
    for (int g = 0; g < 20 && mcount > 0; g++) begin
      step();
      mcount--;
    end
    out_ready = 0;
    chk("t5_sent", 64'(sent), 20);
    chk("t5_count", count, 0);
    chk("t5_instret", instret, 33);
    chk("t5_scoreboard_empty", 64'(exp_q.size()), 0);
    // 6: asynchronous reset mid-cycle with 5 entries held
    drive(2'b11, 32'h400, 32'h404);
    step();
    drive(2'b11, 32'h408, 32'h40C);
    step();
    drive(2'b01, 32'h410, 32'h0);
    step();
    drive(2'b00, 0, 0);
    chk("t6_count_5", count, 5);
    #3 rst_n = 0;
    #1;
    chk("t6_async_count", count, 0);
    chk("t6_async_out_en", out_en, 0);
    chk("t6_async_instret", instret, 0);
    chk("t6_async_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1;
    step();
    drive(2'b11, 32'h500, 32'h504);
    push(2'b11, 32'h500, 32'h504);
    step();
    drive(2'b00, 0, 0);
    chk("t6_refill_count", count, 2);
    chk("t6_refill_pc", out_pc[0], 32'h500);
    out_ready = 1;
    step();
    step();
    out_ready = 0;
    chk("t6_refill_drained", count, 0);
    chk("t6_refill_instret", instret, 2);
    chk("final_scoreboard_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
